// File: rtl/hscaler_n.sv
// rtl/hscaler_n.sv - horizontal scaler with per-channel causal smoothing and NUM/DEN decimation
module hscaler_n #(
  parameter int DW  = 8,
  parameter int NCH = 3,
  parameter int RW  = 4,
  parameter int CW  = 12
) (
  input  logic              clk_scl,
  input  logic              rst_scl,
  input  logic              scl_i_vsync,
  input  logic              scl_i_hsync,
  input  logic              scl_i_data_en,
  input  logic [NCH*DW-1:0] scl_i_data,
  input  logic              scl_cfg_mode,
  input  logic [1:0]        scl_cfg_flt,
  input  logic [RW-1:0]     scl_cfg_num,
  input  logic [RW-1:0]     scl_cfg_den,
  output logic              scl_o_vsync,
  output logic              scl_o_hsync,
  output logic              scl_o_data_en,
  output logic [NCH*DW-1:0] scl_o_data,
  output logic [CW-1:0]     scl_o_pix_cnt
);

  localparam logic [DW+1:0] ONE = (DW+2)'(1);
  localparam logic [DW+1:0] TWO = (DW+2)'(2);

  // config shadows, only updated at frame boundaries
  logic          mode_s;
  logic [1:0]    flt_s;
  logic [RW-1:0] num_s, den_s;

  logic              vs_prev, de_prev;
  logic [NCH*DW-1:0] h1, h2;
  logic [RW:0]       acc;

  logic              s1_en, s1_vs, s1_hs;
  logic [NCH*DW-1:0] s1_data;

  logic              line_start;
  logic [RW-1:0]     num_e, den_e;
  logic [RW:0]       sum;
  logic              keep;
  logic [NCH*DW-1:0] filt;
  logic [DW+1:0]     fc, fp, fq, fs;

  // latch new configuration on the vsync rising edge
  always_ff @(posedge clk_scl) begin
    if (rst_scl) begin
      mode_s <= 1'b0;
      flt_s  <= 2'b00;
      num_s  <= RW'(1);
      den_s  <= RW'(1);
    end else if (scl_i_vsync && !vs_prev) begin
      mode_s <= scl_cfg_mode;
      flt_s  <= scl_cfg_flt;
      num_s  <= scl_cfg_num;
      den_s  <= scl_cfg_den;
    end
  end

  // sanitise the ratio and evaluate this pixel's keep decision
  always_comb begin
    num_e = num_s;
    den_e = den_s;
    if (num_s == '0 || den_s == '0 || num_s > den_s) begin
      num_e = RW'(1);
      den_e = RW'(1);
    end
    line_start = scl_i_data_en && !de_prev;
    sum  = acc + {1'b0, num_e};
    keep = (sum >= {1'b0, den_e});
  end

  // per-channel smoothing with edge replication at line start
  always_comb begin
    filt = '0;
    fc   = '0;
    fp   = '0;
    fq   = '0;
    fs   = '0;
    for (int i = 0; i < NCH; i++) begin
      fc = {2'b00, scl_i_data[i*DW +: DW]};
      fp = line_start ? fc : {2'b00, h1[i*DW +: DW]};
      fq = line_start ? fc : {2'b00, h2[i*DW +: DW]};
      case (flt_s)
        2'b01:   fs = (fc + fp + ONE) >> 1;
        2'b10:   fs = (fc + (fp << 1) + fq + TWO) >> 2;
        default: fs = fc;
      endcase
      filt[i*DW +: DW] = fs[DW-1:0];
    end
  end

  // input history, pixel history and decimation accumulator
  always_ff @(posedge clk_scl) begin
    if (rst_scl) begin
      vs_prev <= 1'b0;
      de_prev <= 1'b0;
      h1      <= '0;
      h2      <= '0;
      acc     <= '0;
    end else begin
      vs_prev <= scl_i_vsync;
      de_prev <= scl_i_data_en;
      if (scl_i_data_en) begin
        h1  <= scl_i_data;
        h2  <= line_start ? scl_i_data : h1;
        acc <= keep ? sum - {1'b0, den_e} : sum;
      end else begin
        acc <= {1'b0, den_e} - {1'b0, num_e};
      end
    end
  end

  // first pipeline stage: filtered pixel, qualified valid and syncs
  always_ff @(posedge clk_scl) begin
    if (rst_scl) begin
      s1_en   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_en   <= scl_i_data_en && (!mode_s || keep);
      s1_vs   <= scl_i_vsync;
      s1_hs   <= scl_i_hsync;
      s1_data <= filt;
    end
  end

  // output stage: data forced to zero whenever not valid
  always_ff @(posedge clk_scl) begin
    if (rst_scl) begin
      scl_o_data_en <= 1'b0;
      scl_o_vsync   <= 1'b0;
      scl_o_hsync   <= 1'b0;
      scl_o_data    <= '0;
    end else begin
      scl_o_data_en <= s1_en;
      scl_o_vsync   <= s1_vs;
      scl_o_hsync   <= s1_hs;
      scl_o_data    <= s1_en ? s1_data : '0;
    end
  end

  // saturating per-line output pixel counter, cleared by output hsync
  always_ff @(posedge clk_scl) begin
    if (rst_scl) begin
      scl_o_pix_cnt <= '0;
    end else if (scl_o_hsync) begin
      scl_o_pix_cnt <= '0;
    end else if (scl_o_data_en && scl_o_pix_cnt != {CW{1'b1}}) begin
      scl_o_pix_cnt <= scl_o_pix_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_hscaler_n.sv
// tb/tb_hscaler_n.sv - self-checking bench for hscaler_n against an arithmetic reference model
module tb_hscaler_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_vs = 1'b0, i_hs = 1'b0, i_de = 1'b0;
  logic [23:0] i_data = '0;
  logic        cfg_mode = 1'b0;
  logic [1:0]  cfg_flt = 2'b00;
  logic [3:0]  cfg_num = 4'd1, cfg_den = 4'd1;
  logic        o_vs, o_hs, o_de;
  logic [23:0] o_data;
  logic [11:0] o_cnt;

  int tests = 0;
  int fails = 0;

  // model of the latched configuration
  logic       m_mode = 1'b0;
  logic [1:0] m_flt = 2'b00;
  int         m_num = 1, m_den = 1;

  logic [23:0] pix [0:63];

  hscaler_n #(.DW(8), .NCH(3), .RW(4), .CW(12)) dut (
    .clk_scl(clk), .rst_scl(rst),
    .scl_i_vsync(i_vs), .scl_i_hsync(i_hs), .scl_i_data_en(i_de), .scl_i_data(i_data),
    .scl_cfg_mode(cfg_mode), .scl_cfg_flt(cfg_flt), .scl_cfg_num(cfg_num), .scl_cfg_den(cfg_den),
    .scl_o_vsync(o_vs), .scl_o_hsync(o_hs), .scl_o_data_en(o_de), .scl_o_data(o_data),
    .scl_o_pix_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mkpix(input int v);
    logic [7:0] a;
    a = v[7:0];
    return {a >> 1, ~a, a};
  endfunction

  // pixel k kept iff (k*num) mod den < num, with bad ratios meaning 1:1
  function automatic bit mdl_keep(input int k);
    if (m_num == 0 || m_den == 0 || m_num > m_den) return 1'b1;
    return ((k * m_num) % m_den) < m_num;
  endfunction

  function automatic logic [23:0] mdl_filt(input int k);
    logic [23:0] r;
    int c, p, q, f;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      c = int'(pix[k][ch*8 +: 8]);
      p = int'(pix[(k > 0) ? k - 1 : 0][ch*8 +: 8]);
      q = int'(pix[(k > 1) ? k - 2 : 0][ch*8 +: 8]);
      case (m_flt)
        2'd1:    f = (c + p + 1) / 2;
        2'd2:    f = (c + 2 * p + q + 2) / 4;
        default: f = c;
      endcase
      r[ch*8 +: 8] = f[7:0];
    end
    return r;
  endfunction

  task automatic vsync_pulse();
    i_vs = 1'b1;
    m_mode = cfg_mode; m_flt = cfg_flt; m_num = int'(cfg_num); m_den = int'(cfg_den);
    @(posedge clk); #1;
    i_vs = 1'b0;
    @(posedge clk); #1;
    chk("vsync_delay", o_vs, 1);
    @(posedge clk); #1;
    chk("vsync_low", o_vs, 0);
  endtask

  // drive one line of n pixels from pix[]; exp_cnt < 0 means use the model's count
  task automatic run_line(input int n, input int exp_cnt);
    int kept, idx;
    logic en_e;
    logic [23:0] d_e;
    kept = 0;
    for (int k = 0; k < n; k++) if (!m_mode || mdl_keep(k)) kept++;
    i_hs = 1'b1; i_de = 1'b0;
    for (int j = 0; j < n + 4; j++) begin
      @(posedge clk); #1;
      if (j == 1) chk("hsync_delay", o_hs, 1);
      if (j >= 2) begin
        idx = j - 2;
        if (idx < n) begin
          en_e = !m_mode || mdl_keep(idx);
          d_e  = en_e ? mdl_filt(idx) : 24'h0;
        end else begin
          en_e = 1'b0;
          d_e  = 24'h0;
        end
        chk($sformatf("en[%0d]", idx), o_de, en_e);
        chk($sformatf("data[%0d]", idx), o_data, d_e);
      end
      i_hs = 1'b0;
      if (j < n) begin
        i_de = 1'b1; i_data = pix[j];
      end else begin
        i_de = 1'b0; i_data = 24'($urandom);
      end
    end
    @(posedge clk); #1;
    chk("pix_cnt", o_cnt, (exp_cnt >= 0) ? exp_cnt : kept);
  endtask

  initial begin
    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_en", o_de, 0);
    chk("rst_data", o_data, 0);
    chk("rst_cnt", o_cnt, 0);
    chk("rst_vs", o_vs, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // pass-through
    cfg_mode = 1'b0; cfg_flt = 2'b00; cfg_num = 4'd1; cfg_den = 4'd1;
    vsync_pulse();
    for (int k = 0; k < 8; k++) pix[k] = mkpix(10 * (k + 1));
    run_line(8, 8);

    // 1/2 decimation
    cfg_mode = 1'b1; cfg_num = 4'd1; cfg_den = 4'd2;
    vsync_pulse();
    for (int k = 0; k < 8; k++) pix[k] = mkpix(k);
    run_line(8, 4);

    // 3/4 decimation, then an illegal 5/3 ratio
    cfg_num = 4'd3; cfg_den = 4'd4;
    vsync_pulse();
    for (int k = 0; k < 8; k++) pix[k] = mkpix(17 * k + 3);
    run_line(8, 6);
    cfg_num = 4'd5; cfg_den = 4'd3;
    vsync_pulse();
    run_line(8, 8);

    // filters
    cfg_mode = 1'b0; cfg_num = 4'd1; cfg_den = 4'd1; cfg_flt = 2'b01;
    vsync_pulse();
    pix[0] = mkpix(100); pix[1] = mkpix(200); pix[2] = mkpix(50);
    run_line(3, 3);
    cfg_flt = 2'b10;
    vsync_pulse();
    for (int k = 0; k < 4; k++) pix[k] = mkpix(40 * k);
    run_line(4, 4);

    // mid-frame config change waits for the next vsync edge
    cfg_mode = 1'b1; cfg_flt = 2'b00; cfg_num = 4'd1; cfg_den = 4'd2;
    vsync_pulse();
    for (int k = 0; k < 8; k++) pix[k] = mkpix(30 + k);
    run_line(8, 4);
    cfg_num = 4'd1; cfg_den = 4'd1;
    run_line(8, 4);
    vsync_pulse();
    run_line(8, 8);

    // reset mid-line
    cfg_num = 4'd1; cfg_den = 4'd2;
    vsync_pulse();
    i_hs = 1'b1;
    @(posedge clk); #1;
    i_hs = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_de = 1'b1; i_data = mkpix(60 + k);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_en", o_de, 0);
    chk("midrst_data", o_data, 0);
    chk("midrst_cnt", o_cnt, 0);
    rst = 1'b0; i_de = 1'b0;
    m_mode = 1'b0; m_flt = 2'b00; m_num = 1; m_den = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("flush_en", o_de, 0);
      chk("flush_data", o_data, 0);
    end
    cfg_mode = 1'b1; cfg_flt = 2'b10; cfg_num = 4'd2; cfg_den = 4'd3;
    vsync_pulse();
    for (int k = 0; k < 6; k++) pix[k] = mkpix(200 - 25 * k);
    run_line(6, 4);

    // randomized frames
    for (int r = 0; r < 10; r++) begin
      int n;
      cfg_mode = 1'($urandom_range(0, 1));
      cfg_flt  = 2'($urandom_range(0, 3));
      cfg_num  = 4'($urandom_range(0, 15));
      cfg_den  = 4'($urandom_range(0, 15));
      vsync_pulse();
      n = int'($urandom_range(1, 24));
      for (int k = 0; k < n; k++) pix[k] = 24'($urandom);
      run_line(n, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
